// File: rtl/alu_decode_stage.sv
// rtl/alu_decode_stage.sv - registered RV32I decode stage driving the ALU operand/select interface
// Optional DECODE_ILLEGAL_EN adds a registered Illegal output for unsupported encodings.
module alu_decode_stage #(
  parameter int WIDTH_DATA_LENGTH   = 32,
  parameter int WIDTH_ALUSEL_LENGTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WIDTH_DATA_LENGTH-1:0]   InstIn,
  input  logic [WIDTH_DATA_LENGTH-1:0]   PCIn,
  input  logic                           InValid,
  output logic                           InReady,
  input  logic                           Flush,
  output logic                           OutValid,
  input  logic                           OutReady,
  output logic [WIDTH_DATA_LENGTH-1:0]   PCOut,
  output logic [WIDTH_ALUSEL_LENGTH-1:0] ALUSel,
  output logic                           ASel,
  output logic [1:0]                     BSel,
  output logic [WIDTH_DATA_LENGTH-1:0]   Imm,
  output logic [4:0]                     Rs1Addr,
  output logic [4:0]                     Rs2Addr,
  output logic [4:0]                     RdAddr,
  output logic [2:0]                     Funct3,
  output logic                           RegWEn,
  output logic                           MemRd,
  output logic                           MemWr,
  output logic                           BrEn,
  output logic                           JmpEn,
  output logic                           WBSel
`ifdef DECODE_ILLEGAL_EN
  ,
  output logic                           Illegal
`endif
);

  localparam int W = WIDTH_DATA_LENGTH;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [WIDTH_ALUSEL_LENGTH-1:0] ALU_ADD   = 'd0;
  localparam logic [WIDTH_ALUSEL_LENGTH-1:0] ALU_LINK  = 'd14;
  localparam logic [WIDTH_ALUSEL_LENGTH-1:0] ALU_PASSB = 'd15;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       rd_nz;
  logic       capture;

  logic [W-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  logic [WIDTH_ALUSEL_LENGTH-1:0] d_alusel;
  logic         d_asel;
  logic [1:0]   d_bsel;
  logic [W-1:0] d_imm;
  logic         d_regwen, d_memrd, d_memwr, d_bren, d_jmpen, d_wbsel, d_illegal;

  assign opcode = InstIn[6:0];
  assign f3     = InstIn[14:12];
  assign f7     = InstIn[31:25];
  assign rd_nz  = |InstIn[11:7];

  assign imm_i  = {{(W-12){InstIn[31]}}, InstIn[31:20]};
  assign imm_s  = {{(W-12){InstIn[31]}}, InstIn[31:25], InstIn[11:7]};
  assign imm_b  = {{(W-13){InstIn[31]}}, InstIn[31], InstIn[7], InstIn[30:25], InstIn[11:8], 1'b0};
  assign imm_u  = {InstIn[W-1:12], 12'b0};
  assign imm_j  = {{(W-21){InstIn[31]}}, InstIn[31], InstIn[19:12], InstIn[20], InstIn[30:21], 1'b0};
  assign imm_sh = {{(W-5){1'b0}}, InstIn[24:20]};

  // funct3 -> ALU select; alt picks SUB (funct3 000) or SRA (funct3 101)
  function automatic logic [WIDTH_ALUSEL_LENGTH-1:0] alu_from_f3(input logic [2:0] fn, input logic alt);
    logic [WIDTH_ALUSEL_LENGTH-1:0] sel;
    sel = ALU_ADD;
    case (fn)
      3'b000:  sel = alt ? 'd1 : 'd0;
      3'b001:  sel = 'd2;
      3'b010:  sel = 'd3;
      3'b011:  sel = 'd4;
      3'b100:  sel = 'd5;
      3'b101:  sel = alt ? 'd7 : 'd6;
      3'b110:  sel = 'd8;
      default: sel = 'd9;
    endcase
    return sel;
  endfunction

  always_comb begin
    d_alusel  = ALU_ADD;
    d_asel    = 1'b0;
    d_bsel    = 2'd0;
    d_imm     = '0;
    d_regwen  = 1'b0;
    d_memrd   = 1'b0;
    d_memwr   = 1'b0;
    d_bren    = 1'b0;
    d_jmpen   = 1'b0;
    d_wbsel   = 1'b0;
    d_illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
          d_alusel = alu_from_f3(f3, InstIn[30]);
          d_regwen = rd_nz;
        end else begin
          d_illegal = 1'b1;
        end
      end
      OPC_OPIMM: begin
        if ((f3 == 3'b001 && f7 != 7'b0000000) ||
            (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000)) begin
          d_illegal = 1'b1;
        end else begin
          d_alusel = alu_from_f3(f3, InstIn[30] && f3 == 3'b101);
          d_bsel   = 2'd1;
          d_imm    = (f3 == 3'b001 || f3 == 3'b101) ? imm_sh : imm_i;
          d_regwen = rd_nz;
        end
      end
      OPC_LOAD: begin
        d_bsel   = 2'd1;
        d_imm    = imm_i;
        d_memrd  = 1'b1;
        d_wbsel  = 1'b1;
        d_regwen = rd_nz;
      end
      OPC_STORE: begin
        d_bsel  = 2'd1;
        d_imm   = imm_s;
        d_memwr = 1'b1;
      end
      OPC_BRANCH: begin
        d_asel = 1'b1;
        d_bsel = 2'd1;
        d_imm  = imm_b;
        d_bren = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        d_alusel = ALU_LINK;
        d_asel   = 1'b1;
        d_bsel   = 2'd2;
        d_imm    = (opcode == OPC_JAL) ? imm_j : imm_i;
        d_jmpen  = 1'b1;
        d_regwen = rd_nz;
      end
      OPC_LUI: begin
        d_alusel = ALU_PASSB;
        d_bsel   = 2'd1;
        d_imm    = imm_u;
        d_regwen = rd_nz;
      end
      OPC_AUIPC: begin
        d_asel   = 1'b1;
        d_bsel   = 2'd1;
        d_imm    = imm_u;
        d_regwen = rd_nz;
      end
      default: d_illegal = 1'b1;
    endcase
  end

  assign InReady = !OutValid || OutReady;
  assign capture = InValid && InReady;

  // Flush outranks capture and hold; data registers may keep stale contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      OutValid <= 1'b0;
      PCOut    <= '0;
      ALUSel   <= '0;
      ASel     <= 1'b0;
      BSel     <= 2'd0;
      Imm      <= '0;
      Rs1Addr  <= 5'd0;
      Rs2Addr  <= 5'd0;
      RdAddr   <= 5'd0;
      Funct3   <= 3'd0;
      RegWEn   <= 1'b0;
      MemRd    <= 1'b0;
      MemWr    <= 1'b0;
      BrEn     <= 1'b0;
      JmpEn    <= 1'b0;
      WBSel    <= 1'b0;
`ifdef DECODE_ILLEGAL_EN
      Illegal  <= 1'b0;
`endif
    end else if (Flush) begin
      OutValid <= 1'b0;
`ifdef DECODE_ILLEGAL_EN
      Illegal  <= 1'b0;
`endif
    end else if (capture) begin
      OutValid <= 1'b1;
      PCOut    <= PCIn;
      ALUSel   <= d_alusel;
      ASel     <= d_asel;
      BSel     <= d_bsel;
      Imm      <= d_imm;
      Rs1Addr  <= InstIn[19:15];
      Rs2Addr  <= InstIn[24:20];
      RdAddr   <= InstIn[11:7];
      Funct3   <= f3;
      RegWEn   <= d_regwen;
      MemRd    <= d_memrd;
      MemWr    <= d_memwr;
      BrEn     <= d_bren;
      JmpEn    <= d_jmpen;
      WBSel    <= d_wbsel;
`ifdef DECODE_ILLEGAL_EN
      Illegal  <= d_illegal;
`endif
    end else if (OutReady) begin
      OutValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb/tb_alu_decode_stage.sv - scoreboard bench for alu_decode_stage
// Directed RV32I vectors; honours DECODE_ILLEGAL_EN when defined.
module tb_alu_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  alusel;
    logic        asel;
    logic [1:0]  bsel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        regwen, memrd, memwr, bren, jmpen, wbsel, illegal;
  } exp_t;

`ifdef DECODE_ILLEGAL_EN
  localparam logic ILL = 1'b1;
`else
  localparam logic ILL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_in, pc_in;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] pc_out, imm;
  logic [3:0]  alusel;
  logic        asel;
  logic [1:0]  bsel;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic        regwen, memrd, memwr, bren, jmpen, wbsel;
  logic        ill_act;

  int checks   = 0;
  int failures = 0;
  int stalls   = 0;

  exp_t        exp_q[$];
  exp_t        vexp[12];
  logic [31:0] vinst[12];
  exp_t        act, mon_e;

  always #5 clk = ~clk;

  alu_decode_stage dut (
    .clk(clk), .rst(rst), .InstIn(inst_in), .PCIn(pc_in), .InValid(in_valid),
    .InReady(in_ready), .Flush(flush), .OutValid(out_valid), .OutReady(out_ready),
    .PCOut(pc_out), .ALUSel(alusel), .ASel(asel), .BSel(bsel), .Imm(imm),
    .Rs1Addr(rs1), .Rs2Addr(rs2), .RdAddr(rd), .Funct3(funct3), .RegWEn(regwen),
    .MemRd(memrd), .MemWr(memwr), .BrEn(bren), .JmpEn(jmpen), .WBSel(wbsel)
`ifdef DECODE_ILLEGAL_EN
    , .Illegal(ill_act)
`endif
  );

`ifndef DECODE_ILLEGAL_EN
  assign ill_act = 1'b0;
`endif

  assign act = {pc_out, alusel, asel, bsel, imm, rs1, rs2, rd, funct3,
                regwen, memrd, memwr, bren, jmpen, wbsel, ill_act};

  // Monitor: one comparison per bundle accepted by the execute side
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_bundle got=%h", act);
      end else begin
        mon_e = exp_q.pop_front();
        if (act !== mon_e) begin
          failures++;
          $display("FAIL bundle pc=%h got=%h exp=%h", mon_e.pc, act, mon_e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic send(input int idx, input logic [31:0] pc);
    int   waited;
    exp_t e;
    inst_in  = vinst[idx];
    pc_in    = pc;
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout idx=%0d got=stalled exp=accepted", idx);
      in_valid = 1'b0;
    end else begin
      e    = vexp[idx];
      e.pc = pc;
      exp_q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      stalls += waited;
    end
  endtask

  initial begin
    // fields: pc alusel asel bsel imm rs1 rs2 rd f3 regwen memrd memwr bren jmpen wbsel illegal
    vinst[0]  = 32'h002081B3; vexp[0]  = '{32'h0, 4'h0, 1'b0, 2'd0, 32'h0,        5'd1,  5'd2,  5'd3,  3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vinst[1]  = 32'h402081B3; vexp[1]  = '{32'h0, 4'h1, 1'b0, 2'd0, 32'h0,        5'd1,  5'd2,  5'd3,  3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vinst[2]  = 32'h40335293; vexp[2]  = '{32'h0, 4'h7, 1'b0, 2'd1, 32'h3,        5'd6,  5'd3,  5'd5,  3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vinst[3]  = 32'h123450B7; vexp[3]  = '{32'h0, 4'hF, 1'b0, 2'd1, 32'h12345000, 5'd8,  5'd3,  5'd1,  3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vinst[4]  = 32'h12345037; vexp[4]  = '{32'h0, 4'hF, 1'b0, 2'd1, 32'h12345000, 5'd8,  5'd3,  5'd0,  3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vinst[5]  = 32'hFFFFFFFF; vexp[5]  = '{32'h0, 4'h0, 1'b0, 2'd0, 32'h0,        5'd31, 5'd31, 5'd31, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ILL};
    vinst[6]  = 32'hFFC12383; vexp[6]  = '{32'h0, 4'h0, 1'b0, 2'd1, 32'hFFFFFFFC, 5'd2,  5'd28, 5'd7,  3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vinst[7]  = 32'h00512423; vexp[7]  = '{32'h0, 4'h0, 1'b0, 2'd1, 32'h8,        5'd2,  5'd5,  5'd8,  3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vinst[8]  = 32'hFE208CE3; vexp[8]  = '{32'h0, 4'h0, 1'b1, 2'd1, 32'hFFFFFFF8, 5'd1,  5'd2,  5'd25, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vinst[9]  = 32'h010000EF; vexp[9]  = '{32'h0, 4'hE, 1'b1, 2'd2, 32'h10,       5'd0,  5'd16, 5'd1,  3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vinst[10] = 32'h00001217; vexp[10] = '{32'h0, 4'h0, 1'b1, 2'd1, 32'h1000,     5'd0,  5'd0,  5'd4,  3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vinst[11] = 32'h02009093; vexp[11] = '{32'h0, 4'h0, 1'b0, 2'd0, 32'h0,        5'd1,  5'd0,  5'd1,  3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ILL};

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    inst_in = 32'h0; pc_in = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outvalid", {31'b0, out_valid}, 32'h0);
    chk("reset_inready", {31'b0, in_ready}, 32'h1);
    chk("reset_pcout", pc_out, 32'h0);
    chk("reset_imm", imm, 32'h0);
    chk("reset_alusel_regwen", {27'b0, alusel, regwen}, 32'h0);
    chk("reset_illegal", {31'b0, ill_act}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // back-to-back stream at one instruction per cycle
    for (int i = 0; i < 12; i++) send(i, 32'h1000 + 32'(i) * 4);
    chk("stream_no_stall", 32'(stalls), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("drain_outvalid", {31'b0, out_valid}, 32'h0);
    chk("stream_queue_empty", 32'(exp_q.size()), 32'h0);

    // backpressure: first bundle held, second offered, no loss/duplicate
    out_ready = 1'b0;
    send(0, 32'h2000);
    inst_in = vinst[3]; pc_in = 32'h2004; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp_inready", {31'b0, in_ready}, 32'h0);
      chk("bp_hold_pc", pc_out, 32'h2000);
      chk("bp_hold_alusel_rd", {23'b0, alusel, rd}, {23'b0, vexp[0].alusel, vexp[0].rd});
    end
    mon_e = vexp[3];
    mon_e.pc = 32'h2004;
    exp_q.push_back(mon_e);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_pc", pc_out, 32'h2004);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_queue_empty", 32'(exp_q.size()), 32'h0);

    // flush kills held and incoming instruction
    out_ready = 1'b0;
    send(11, 32'h3000);
    chk("flush_pre_valid", {31'b0, out_valid}, 32'h1);
    chk("flush_pre_illegal", {31'b0, ill_act}, {31'b0, ILL});
    inst_in = vinst[0]; pc_in = 32'h3004; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    chk("flush_outvalid", {31'b0, out_valid}, 32'h0);
    chk("flush_illegal_cleared", {31'b0, ill_act}, 32'h0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("flush_no_ghost", {31'b0, out_valid}, 32'h0);

    // async reset while holding
    out_ready = 1'b0;
    send(2, 32'h4000);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_outvalid", {31'b0, out_valid}, 32'h0);
    chk("async_rst_pcout", pc_out, 32'h0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(9, 32'h5000);
    repeat (2) @(posedge clk);
    #1;
    chk("final_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
